// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage feeding the decode stage through IF_ID.
// Holds the PC, issues one request per word to a wait-stated instruction
// memory, and delivers {PC+4, instruction} to decode. Honours the decode
// stall (bubble), the decode redirects (j/jal, jr/jalr) and the execute
// redirect (taken branch), flushing wrong-path words with nops (all-zero).
//
// Ports:
//   clk, reset_b              clock, asynchronous active-low reset
//   bubble                    decode stall; IF_ID holds
//   PCSrcJ / jump_address     decode redirect for j/jal
//   PCSrcJR / jr_address      decode redirect for jr/jalr
//   EX_BranchTaken /
//   EX_branch_address         execute redirect for a taken branch
//   imem_req / imem_addr      fetch request and its address
//   imem_ready / imem_rdata   fetch completion and fetched word
//   IF_ID                     {PC+4, instruction} pipeline register
//   IF_ID_Rs / IF_ID_Rt       rs / rt fields of the instruction in IF_ID
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        bubble,
    input  logic        PCSrcJ,
    input  logic        PCSrcJR,
    input  logic [31:0] jump_address,
    input  logic [31:0] jr_address,
    input  logic        EX_BranchTaken,
    input  logic [31:0] EX_branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [63:0] IF_ID,
    output logic [4:0]  IF_ID_Rs,
    output logic [4:0]  IF_ID_Rt
);

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StDiscard,
        StHeld
    } state_e;

    state_e      r_state, w_state_d;
    logic [31:0] r_pc, w_pc_d;
    logic [31:0] r_req_addr, w_req_addr_d;
    logic [31:0] r_skid_word, w_skid_word_d;
    logic [31:0] r_skid_pc4, w_skid_pc4_d;
    logic [63:0] r_if_id, w_if_id_d;

    logic        w_dec_j;
    logic        w_dec_jr;
    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // Decode redirects wait while decode is stalled: the jump is still
    // sitting in decode and will be presented again.
    assign w_dec_j    = PCSrcJ & ~bubble;
    assign w_dec_jr   = PCSrcJR & ~bubble;
    assign w_redirect = EX_BranchTaken | w_dec_jr | w_dec_j;

    always_comb begin
        w_target_raw = jump_address;
        if (EX_BranchTaken) begin
            w_target_raw = EX_branch_address;
        end else if (w_dec_jr) begin
            w_target_raw = jr_address;
        end
    end

    assign w_target   = w_target_raw & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_pc + 32'd4;  // wraps modulo 2^32

    always_comb begin
        w_state_d     = r_state;
        w_pc_d        = r_pc;
        w_req_addr_d  = r_req_addr;
        w_skid_word_d = r_skid_word;
        w_skid_pc4_d  = r_skid_pc4;
        w_if_id_d     = r_if_id;

        unique case (r_state)
            StBoot: begin
                if (w_redirect) begin
                    w_pc_d    = w_target;
                    w_if_id_d = '0;
                end
                w_state_d = StFetch;
            end
            StFetch: begin
                if (w_redirect) begin
                    // Any word arriving now is wrong-path.
                    w_if_id_d = '0;
                    w_pc_d    = w_target;
                    w_state_d = imem_ready ? StFetch : StDiscard;
                end else if (imem_ready) begin
                    w_pc_d = w_pc_plus4;
                    if (bubble) begin
                        w_skid_word_d = imem_rdata;
                        w_skid_pc4_d  = w_pc_plus4;
                        w_state_d     = StHeld;
                    end else begin
                        w_if_id_d = {w_pc_plus4, imem_rdata};
                    end
                end else if (!bubble) begin
                    w_if_id_d = '0;
                end
            end
            StDiscard: begin
                // Outstanding request keeps its stale address; only pc moves.
                if (w_redirect) begin
                    w_pc_d = w_target;
                end
                if (w_redirect || !bubble) begin
                    w_if_id_d = '0;
                end
                if (imem_ready) begin
                    w_state_d = StFetch;
                end
            end
            StHeld: begin
                if (w_redirect) begin
                    w_if_id_d = '0;
                    w_pc_d    = w_target;
                    w_state_d = StFetch;
                end else if (!bubble) begin
                    w_if_id_d = {r_skid_pc4, r_skid_word};
                    w_state_d = StFetch;
                end
            end
            default: begin
                w_state_d = StBoot;
            end
        endcase

        // Entering (or staying in) FETCH always requests the current pc.
        if (w_state_d == StFetch) begin
            w_req_addr_d = w_pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= StBoot;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_skid_word <= '0;
            r_skid_pc4  <= '0;
            r_if_id     <= '0;
        end else begin
            r_state     <= w_state_d;
            r_pc        <= w_pc_d;
            r_req_addr  <= w_req_addr_d;
            r_skid_word <= w_skid_word_d;
            r_skid_pc4  <= w_skid_pc4_d;
            r_if_id     <= w_if_id_d;
        end
    end

    assign imem_req  = (r_state == StFetch) || (r_state == StDiscard);
    assign imem_addr = r_req_addr;
    assign IF_ID     = r_if_id;
    assign IF_ID_Rs  = r_if_id[25:21];
    assign IF_ID_Rt  = r_if_id[20:16];

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. The instruction memory returns
// 0x2001_0001 + (addr >> 2) for any address; the bench controls imem_ready.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        reset_b;
    logic        bubble;
    logic        PCSrcJ;
    logic        PCSrcJR;
    logic [31:0] jump_address;
    logic [31:0] jr_address;
    logic        EX_BranchTaken;
    logic [31:0] EX_branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [63:0] IF_ID;
    logic [4:0]  IF_ID_Rs;
    logic [4:0]  IF_ID_Rt;

    int n_total;
    int n_bad;

    if_stage #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset_b          (reset_b),
        .bubble           (bubble),
        .PCSrcJ           (PCSrcJ),
        .PCSrcJR          (PCSrcJR),
        .jump_address     (jump_address),
        .jr_address       (jr_address),
        .EX_BranchTaken   (EX_BranchTaken),
        .EX_branch_address(EX_branch_address),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .IF_ID            (IF_ID),
        .IF_ID_Rs         (IF_ID_Rs),
        .IF_ID_Rt         (IF_ID_Rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = 32'h2001_0001 + {2'b00, imem_addr[31:2]};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total           = 0;
        n_bad             = 0;
        reset_b           = 1'b0;
        bubble            = 1'b0;
        PCSrcJ            = 1'b0;
        PCSrcJR           = 1'b0;
        jump_address      = '0;
        jr_address        = '0;
        EX_BranchTaken    = 1'b0;
        EX_branch_address = '0;
        imem_ready        = 1'b1;

        // Reset state
        #2;
        check_eq("rst_ifid", IF_ID, 64'h0);
        check_eq("rst_req", {63'h0, imem_req}, 64'h0);
        check_eq("rst_addr", {32'h0, imem_addr}, 64'h0);
        step();
        step();
        reset_b = 1'b1;
        check_eq("boot_req", {63'h0, imem_req}, 64'h0);

        // First request one cycle after reset release, then one word per cycle
        step();
        check_eq("first_req", {63'h0, imem_req}, 64'h1);
        check_eq("first_addr", {32'h0, imem_addr}, 64'h0);
        step();
        check_eq("stream0", IF_ID, 64'h0000_0004_2001_0001);
        check_eq("stream0_rs", {59'h0, IF_ID_Rs}, 64'h0);
        check_eq("stream0_rt", {59'h0, IF_ID_Rt}, 64'h1);
        step();
        check_eq("stream1", IF_ID, 64'h0000_0008_2001_0002);
        step();
        check_eq("stream2", IF_ID, 64'h0000_000C_2001_0003);
        step();
        check_eq("stream3", IF_ID, 64'h0000_0010_2001_0004);
        check_eq("addr_10", {32'h0, imem_addr}, 64'h10);

        // Bubble for two cycles while the word at 0x10 arrives
        bubble = 1'b1;
        step();
        check_eq("held_ifid0", IF_ID, 64'h0000_0010_2001_0004);
        check_eq("held_req0", {63'h0, imem_req}, 64'h0);
        step();
        check_eq("held_ifid1", IF_ID, 64'h0000_0010_2001_0004);
        check_eq("held_req1", {63'h0, imem_req}, 64'h0);
        bubble = 1'b0;
        step();
        check_eq("skid_out", IF_ID, 64'h0000_0014_2001_0005);
        check_eq("after_skid_addr", {32'h0, imem_addr}, 64'h14);
        check_eq("after_skid_req", {63'h0, imem_req}, 64'h1);
        step();
        check_eq("after_skid_word", IF_ID, 64'h0000_0018_2001_0006);

        // Decode jump
        PCSrcJ       = 1'b1;
        jump_address = 32'h0040_0100;
        step();
        PCSrcJ = 1'b0;
        check_eq("j_nop", IF_ID, 64'h0);
        check_eq("j_addr", {32'h0, imem_addr}, 64'h0040_0100);
        step();
        check_eq("j_word", IF_ID, 64'h0040_0104_2011_0041);
        check_eq("j_word_rt", {59'h0, IF_ID_Rt}, 64'h11);

        // Execute branch beats a stalled jr in the same cycle
        EX_BranchTaken    = 1'b1;
        EX_branch_address = 32'h0000_0200;
        PCSrcJR           = 1'b1;
        jr_address        = 32'h0000_0300;
        bubble            = 1'b1;
        step();
        EX_BranchTaken = 1'b0;
        PCSrcJR        = 1'b0;
        bubble         = 1'b0;
        check_eq("br_nop", IF_ID, 64'h0);
        check_eq("br_addr", {32'h0, imem_addr}, 64'h200);
        step();
        check_eq("br_word", IF_ID, 64'h0000_0204_2001_0081);

        // Three wait states, redirect to 0x80 in the first one
        imem_ready   = 1'b0;
        PCSrcJ       = 1'b1;
        jump_address = 32'h0000_0080;
        step();
        PCSrcJ = 1'b0;
        check_eq("disc_nop0", IF_ID, 64'h0);
        check_eq("disc_addr0", {32'h0, imem_addr}, 64'h204);
        check_eq("disc_req0", {63'h0, imem_req}, 64'h1);
        step();
        check_eq("disc_addr1", {32'h0, imem_addr}, 64'h204);
        step();
        check_eq("disc_addr2", {32'h0, imem_addr}, 64'h204);
        imem_ready = 1'b1;
        step();
        check_eq("disc_drop", IF_ID, 64'h0);
        check_eq("disc_new_addr", {32'h0, imem_addr}, 64'h80);
        step();
        check_eq("disc_target", IF_ID, 64'h0000_0084_2001_0021);

        // Wait cycle in FETCH without stall inserts a nop
        imem_ready = 1'b0;
        step();
        check_eq("wait_nop", IF_ID, 64'h0);
        check_eq("wait_addr", {32'h0, imem_addr}, 64'h84);

        // Jump with unaligned target, then PC+4 wrap
        imem_ready   = 1'b1;
        PCSrcJ       = 1'b1;
        jump_address = 32'hFFFF_FFFF;
        step();
        PCSrcJ = 1'b0;
        check_eq("align_addr", {32'h0, imem_addr}, 64'hFFFF_FFFC);
        step();
        check_eq("wrap_word", IF_ID, 64'h0000_0000_6001_0000);
        check_eq("wrap_addr", {32'h0, imem_addr}, 64'h0);
        step();
        check_eq("wrap_next", IF_ID, 64'h0000_0004_2001_0001);

        // Reset in the middle of a stalled wait
        imem_ready = 1'b0;
        bubble     = 1'b1;
        step();
        check_eq("pre_rst_ifid", IF_ID, 64'h0000_0004_2001_0001);
        check_eq("pre_rst_addr", {32'h0, imem_addr}, 64'h4);
        reset_b = 1'b0;
        #1;
        check_eq("mid_rst_ifid", IF_ID, 64'h0);
        check_eq("mid_rst_req", {63'h0, imem_req}, 64'h0);
        check_eq("mid_rst_addr", {32'h0, imem_addr}, 64'h0);
        step();
        reset_b    = 1'b1;
        bubble     = 1'b0;
        imem_ready = 1'b1;
        check_eq("re_boot_req", {63'h0, imem_req}, 64'h0);
        step();
        check_eq("re_first_req", {63'h0, imem_req}, 64'h1);
        check_eq("re_first_addr", {32'h0, imem_addr}, 64'h0);
        step();
        check_eq("re_first_word", IF_ID, 64'h0000_0004_2001_0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
